sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Parametrised, handshaked controller for an asynchronous external SRAM with an active-low CE/OE/WE interface.
- Accepts one read or write request at a time from a user-side valid/ready port, with per-byte enables.
- Generates pin timing with a programmable number of wait cycles and returns read data on a one-cycle response strobe.
- Sits between application logic (switch/LED demo, future DMA) and the board SRAM pins.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, data bus width; must be a multiple of 8.
- BE_W, DATA_W/8, number of byte lanes (derived, not overridden).
- WAIT_CYCLES, 1, extra cycles strobes stay asserted beyond the minimum one; legal range 0..15.

Ports:
- clock_50mhz  in  1  system clock, all logic on rising edge.
- pinReset  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle, request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  BE_W  byte enables, active-high.
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_rdata  out  DATA_W  read data, disabled bytes forced to 0.
- pinAddr  out  ADDR_W  SRAM address.
- pinData  inout  DATA_W  SRAM data bus.
- pinCE  out  1  chip enable, active-low.
- pinOE  out  1  output enable, active-low.
- pinWE  out  1  write enable, active-low.
- pinBE  out  BE_W  byte-lane enables, active-low (lane 1 = UB, lane 0 = LB for DATA_W=16).

Behaviour:
- All pin outputs and rsp_valid/rsp_rdata are registered.
- Reset values: pinCE=pinOE=pinWE=1, pinBE=all 1, pinAddr=0, pinData=Z, req_ready=1, rsp_valid=0, rsp_rdata=0, FSM=IDLE.
- IDLE:
  - req_ready=1.
  - On handshake, latch addr, wdata, be and write; drive pinAddr.
  - Go to WR_ASSERT or RD_ASSERT; req_ready=0 from the next cycle.
- WR_ASSERT, W+1 cycles (W=WAIT_CYCLES):
  - pinCE=0, pinWE=0, pinBE=~be.
  - pinData driven with wdata.
  - Then WR_HOLD.
- WR_HOLD, 1 cycle:
  - pinCE=pinWE=1, pinBE=all 1.
  - pinData still driven (data hold).
  - Then IDLE, where pinData returns to Z.
- RD_ASSERT, W+1 cycles:
  - pinCE=0, pinOE=0, pinBE=~be, pinData=Z.
  - On the final edge, capture pinData & byte mask into rsp_rdata.
  - Then RD_END.
- RD_END, 1 cycle:
  - Strobes deasserted, rsp_valid=1.
  - Then IDLE.
- Latency and occupancy:
  - Write occupies W+2 cycles after the accept edge.
  - For a read, rsp_valid is high in cycle W+2 after the accept edge.
  - req_ready returns W+2 cycles after accept for both.
- Bus turnaround: minimum one IDLE cycle between any two transfers. pinData is never driven while pinOE=0.
- Wait counter width is 4 bits; it loads W on entering an ASSERT state and exits when it reaches 0. W=0 gives a single-cycle strobe.
- req_be=0 is legal: the transfer runs with all pinBE=1, a write changes nothing, and a read returns 0.
- Request inputs are ignored while req_ready=0. Latched values hold until the transfer ends.
- rsp_rdata holds its value until the next read capture.
- Reset mid-transfer: pins return to inactive immediately (asynchronous), bus goes to Z, the transfer is dropped, and no rsp_valid is produced.

Decomposition:
- Shared package sram_pkg holds:
  - the FSM state enum (IDLE, WR_ASSERT, WR_HOLD, RD_ASSERT, RD_END);
  - the default ADDR_W/DATA_W;
  - a function expanding byte enables to a bit mask.
- One sub-module, sram_wait_timer: 4-bit loadable down-counter with load/done, reused by both ASSERT states.

Test Plan:
1. W=1, write addr 10 data 16'hA55A be=2'b11 -> pinCE/pinWE low exactly 2 cycles, pinBE=00, pinData=A55A for 3 cycles, req_ready high 3 cycles after accept.
2. W=1, read addr 10 after test 1 (SRAM model) -> pinOE low 2 cycles, pinData Z throughout, rsp_valid single pulse 3 cycles after accept, rsp_rdata=16'hA55A.
3. Write 16'h1234 be=2'b01 to addr 11 over prior 16'hFFFF, then read be=2'b11 -> rsp_rdata=16'hFF34. Read with be=2'b10 -> 16'hFF00.
4. W=0 and W=15, back-to-back write then read with req_valid held high -> strobe widths 1 and 16 cycles, at least one IDLE cycle between transfers, no cycle with pinData driven while pinOE=0.
5. Assert pinReset low during RD_ASSERT -> all strobes high and pinData Z in the same cycle, no rsp_valid, req_ready=1 after release. A new request then completes normally.
6. req_be=0 read of addr 12 -> pinBE stays all 1, rsp_valid pulses with rsp_rdata=0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types, defaults and helpers for the asynchronous SRAM controller.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned WAIT_W      = 4;
  localparam int unsigned MAX_BE_W    = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_ASSERT = 3'd1,
    WR_HOLD   = 3'd2,
    RD_ASSERT = 3'd3,
    RD_END    = 3'd4
  } sram_state_e;

  // Widest supported mask; callers cast the result down to their data width.
  function automatic logic [MAX_BE_W*8-1:0] be_to_mask(input logic [MAX_BE_W-1:0] be);
    logic [MAX_BE_W*8-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_BE_W; i++) begin
      mask[i*8 +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable 4-bit down-counter that times the strobe-assert phase of a transfer.
module sram_wait_timer
  import sram_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WAIT_W-1:0] load_val_i,
  output logic              done_o
);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  // Next count: reload on request, otherwise run down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != {WAIT_W{1'b0}}) begin
      count_d = count_q - {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {WAIT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == {WAIT_W{1'b0}});

endmodule

// File: rtl/sram_ctrl.sv
// Single-outstanding valid/ready controller for an asynchronous SRAM with
// active-low CE/OE/WE/BE pins and a programmable strobe width.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter  int unsigned ADDR_W      = SRAM_ADDR_W,
  parameter  int unsigned DATA_W      = SRAM_DATA_W,
  parameter  int unsigned WAIT_CYCLES = 1,
  localparam int unsigned BE_W        = DATA_W / 8
) (
  input  logic              clock_50mhz,
  input  logic              pinReset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] pinAddr,
  inout  wire  [DATA_W-1:0] pinData,
  output logic              pinCE,
  output logic              pinOE,
  output logic              pinWE,
  output logic [BE_W-1:0]   pinBE
);

  sram_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              data_oe_q;
  logic              ce_q;
  logic              oe_q;
  logic              we_q;
  logic [BE_W-1:0]   pin_be_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              accept_s;
  logic              timer_done_s;
  logic [DATA_W-1:0] be_mask_s;

  assign accept_s  = (state_q == IDLE) && req_valid && ready_q;
  assign be_mask_s = DATA_W'(be_to_mask(MAX_BE_W'(be_q)));

  sram_wait_timer u_timer (
    .clk_i      (clock_50mhz),
    .rst_ni     (pinReset),
    .load_i     (accept_s),
    .load_val_i (WAIT_W'(WAIT_CYCLES)),
    .done_o     (timer_done_s)
  );

  // Transfer sequencer; every pin and response output comes straight from here.
  always_ff @(posedge clock_50mhz or negedge pinReset) begin
    if (!pinReset) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      be_q        <= {BE_W{1'b0}};
      data_oe_q   <= 1'b0;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      pin_be_q    <= {BE_W{1'b1}};
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            be_q     <= req_be;
            ready_q  <= 1'b0;
            ce_q     <= 1'b0;
            pin_be_q <= ~req_be;
            if (req_write) begin
              we_q      <= 1'b0;
              data_oe_q <= 1'b1;
              state_q   <= WR_ASSERT;
            end else begin
              oe_q    <= 1'b0;
              state_q <= RD_ASSERT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WR_ASSERT: begin
          if (timer_done_s) begin
            ce_q     <= 1'b1;
            we_q     <= 1'b1;
            pin_be_q <= {BE_W{1'b1}};
            state_q  <= WR_HOLD;
          end else begin
            state_q <= WR_ASSERT;
          end
        end
        WR_HOLD: begin
          // Data stays on the bus one cycle past WE release for hold time.
          data_oe_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
        RD_ASSERT: begin
          if (timer_done_s) begin
            rsp_rdata_q <= pinData & be_mask_s;
            rsp_valid_q <= 1'b1;
            ce_q        <= 1'b1;
            oe_q        <= 1'b1;
            pin_be_q    <= {BE_W{1'b1}};
            state_q     <= RD_END;
          end else begin
            state_q <= RD_ASSERT;
          end
        end
        RD_END: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          data_oe_q <= 1'b0;
          ce_q      <= 1'b1;
          oe_q      <= 1'b1;
          we_q      <= 1'b1;
          pin_be_q  <= {BE_W{1'b1}};
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign pinData   = data_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign pinAddr   = addr_q;
  assign pinCE     = ce_q;
  assign pinOE     = oe_q;
  assign pinWE     = we_q;
  assign pinBE     = pin_be_q;
  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: three instances (W=1, W=0, W=15), each with a
// behavioural SRAM on its bus, and a scoreboard of expected read responses.
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam int NI = 3;

  typedef struct packed {
    logic [1:0]  g;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_write [NI];
  logic [19:0] req_addr  [NI];
  logic [15:0] req_wdata [NI];
  logic [1:0]  req_be    [NI];
  logic        rsp_valid [NI];
  logic [15:0] rsp_rdata [NI];
  logic [19:0] pin_addr  [NI];
  logic        pin_ce    [NI];
  logic        pin_oe    [NI];
  logic        pin_we    [NI];
  logic [1:0]  pin_be    [NI];
  logic [15:0] bus_obs   [NI];
  logic        drv_obs   [NI];

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wire  [15:0] pin_data;
    logic [15:0] mem [16] = '{default: 16'h0000};

    sram_ctrl #(
      .ADDR_W      (20),
      .DATA_W      (16),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 15))
    ) u_dut (
      .clock_50mhz (clk),
      .pinReset    (rst_n[g]),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_write   (req_write[g]),
      .req_addr    (req_addr[g]),
      .req_wdata   (req_wdata[g]),
      .req_be      (req_be[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_rdata   (rsp_rdata[g]),
      .pinAddr     (pin_addr[g]),
      .pinData     (pin_data),
      .pinCE       (pin_ce[g]),
      .pinOE       (pin_oe[g]),
      .pinWE       (pin_we[g]),
      .pinBE       (pin_be[g])
    );

    // SRAM model: drives the whole word on a read, writes enabled lanes while WE is low.
    assign pin_data = (!pin_ce[g] && !pin_oe[g] && pin_we[g]) ? mem[pin_addr[g][3:0]] : 16'bz;
    assign bus_obs[g] = pin_data;
    assign drv_obs[g] = u_dut.data_oe_q;

    always @(posedge clk) begin
      if (!pin_ce[g] && !pin_we[g]) begin
        for (int l = 0; l < 2; l++) begin
          if (!pin_be[g][l]) mem[pin_addr[g][3:0]][l*8 +: 8] <= pin_data[l*8 +: 8];
        end
      end
    end
  end

  function automatic int wv(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 15);
  endfunction

  function automatic logic [7:0] obs_vec(input int g);
    return {pin_ce[g], pin_oe[g], pin_we[g], pin_be[g], drv_obs[g], req_ready[g], rsp_valid[g]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus must never be driven by the controller while the SRAM outputs are enabled.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rst_n[g]) chk($sformatf("contention_g%0d", g), {31'h0, drv_obs[g] & ~pin_oe[g]}, 32'h0);
    end
  end

  // Response side of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < NI; g++) begin
      if (rsp_valid[g] === 1'b1) begin
        if (sb.size() == 0) begin
          chk($sformatf("rsp_unexpected_g%0d", g), 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("rsp_inst", 32'(g), {30'h0, e.g});
          chk($sformatf("rsp_rdata_g%0d", g), {16'h0, rsp_rdata[g]}, {16'h0, e.data});
        end
      end
    end
  end

  task automatic present(input int g, input logic wr, input logic [19:0] addr,
                         input logic [15:0] data, input logic [1:0] be);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready[g] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ready_wait_g%0d", g), {31'h0, req_ready[g]}, 32'h1);
    req_valid[g] = 1'b1;
    req_write[g] = wr;
    req_addr[g]  = addr;
    req_wdata[g] = data;
    req_be[g]    = be;
  endtask

  // Called at the negedge of cycle 1 after the accept edge; ends at the IDLE cycle.
  task automatic check_xfer(input int g, input logic wr, input logic [19:0] addr,
                            input logic [15:0] data, input logic [1:0] be);
    int         w;
    logic [7:0] e;
    w = wv(g);
    for (int k = 1; k <= w + 2; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= w + 1) e = {1'b0, wr, ~wr, ~be, wr, 1'b0, 1'b0};
      else            e = {1'b1, 1'b1, 1'b1, 2'b11, wr, 1'b0, ~wr};
      chk($sformatf("pins_g%0d_wr%0d_k%0d", g, wr, k), {24'h0, obs_vec(g)}, {24'h0, e});
      if (k == 1) chk($sformatf("addr_g%0d", g), {12'h0, pin_addr[g]}, {12'h0, addr});
      if (wr)     chk($sformatf("wdata_g%0d_k%0d", g, k), {16'h0, bus_obs[g]}, {16'h0, data});
    end
    @(negedge clk);
    chk($sformatf("idle_g%0d_wr%0d", g, wr), {24'h0, obs_vec(g)}, {24'h0, 8'b1111_1010});
  endtask

  task automatic xfer(input int g, input logic wr, input logic [19:0] addr,
                      input logic [15:0] data, input logic [1:0] be, input logic [15:0] exp);
    exp_t e;
    present(g, wr, addr, data, be);
    if (!wr) begin
      e.g    = 2'(g);
      e.data = exp;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[g] = 1'b0;
    check_xfer(g, wr, addr, data, be);
  endtask

  // Write then read with req_valid held; read fields change while the write is busy.
  task automatic b2b(input int g, input logic [19:0] addr, input logic [15:0] data);
    exp_t e;
    present(g, 1'b1, addr, data, 2'b11);
    @(posedge clk);
    @(negedge clk);
    req_write[g] = 1'b0;
    req_wdata[g] = 16'h0000;
    e.g    = 2'(g);
    e.data = data;
    sb.push_back(e);
    check_xfer(g, 1'b1, addr, data, 2'b11);
    @(posedge clk);
    @(negedge clk);
    req_valid[g] = 1'b0;
    check_xfer(g, 1'b0, addr, 16'h0000, 2'b11);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    for (int g = 0; g < NI; g++) begin
      rst_n[g]     = 1'b1;
      req_valid[g] = 1'b0;
      req_write[g] = 1'b0;
      req_addr[g]  = 20'h0;
      req_wdata[g] = 16'h0;
      req_be[g]    = 2'b00;
    end
    #2;
    for (int g = 0; g < NI; g++) rst_n[g] = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("reset_pins_g%0d", g), {24'h0, obs_vec(g)}, {24'h0, 8'b1111_1010});
      chk($sformatf("reset_addr_g%0d", g), {12'h0, pin_addr[g]}, 32'h0);
      chk($sformatf("reset_rdata_g%0d", g), {16'h0, rsp_rdata[g]}, 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) rst_n[g] = 1'b1;

    // Basic write/read at W=1
    xfer(0, 1'b1, 20'd10, 16'hA55A, 2'b11, 16'h0000);
    xfer(0, 1'b0, 20'd10, 16'h0000, 2'b11, 16'hA55A);

    // Partial-lane write and masked reads
    xfer(0, 1'b1, 20'd11, 16'hFFFF, 2'b11, 16'h0000);
    xfer(0, 1'b1, 20'd11, 16'h1234, 2'b01, 16'h0000);
    xfer(0, 1'b0, 20'd11, 16'h0000, 2'b11, 16'hFF34);
    xfer(0, 1'b0, 20'd11, 16'h0000, 2'b10, 16'hFF00);

    // Zero byte enables: no write effect, zero read data
    xfer(0, 1'b1, 20'd12, 16'hBEEF, 2'b11, 16'h0000);
    xfer(0, 1'b1, 20'd12, 16'h0000, 2'b00, 16'h0000);
    xfer(0, 1'b0, 20'd12, 16'h0000, 2'b00, 16'h0000);
    xfer(0, 1'b0, 20'd12, 16'h0000, 2'b11, 16'hBEEF);

    // Back-to-back at the strobe-width extremes
    b2b(1, 20'd20, 16'h5AA5);
    b2b(2, 20'd21, 16'hC3C3);

    // Asynchronous reset in the middle of a W=15 read
    present(2, 1'b0, 20'd21, 16'h0000, 2'b11);
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_read_pins", {24'h0, obs_vec(2)}, {24'h0, 8'b0010_0000});
    #2;
    rst_n[2] = 1'b0;
    #1;
    chk("async_reset_pins", {24'h0, obs_vec(2)}, {24'h0, 8'b1111_1010});
    chk("async_reset_addr", {12'h0, pin_addr[2]}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (20) @(negedge clk);
    chk("ready_after_reset", {31'h0, req_ready[2]}, 32'h1);
    xfer(2, 1'b0, 20'd21, 16'h0000, 2'b11, 16'hC3C3);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
